gray2tint: RTL
==============

GRAY2TINT -- requirements
Module: gray2tint

Interface
REQ-001 Parameter DW, default 8, luma/colour channel width in bits (DW >= 8).
REQ-002 clk  input  1  system clock; every register updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 enable  input  1  high: apply tint; low: grey passthrough.
REQ-005 y_in  input  DW  luma sample, e.g. the grey output of the upstream RGB-to-grayscale converter.
REQ-006 hs_in, vs_in, hb_in, vb_in  input  1 each  horizontal sync, vertical sync, horizontal blank, vertical blank.
REQ-007 cfg_valid  input  1  tint write request.
REQ-008 cfg_data  input  24  requested tint, bits [23:16]=R, [15:8]=G, [7:0]=B.
REQ-009 cfg_ready  output  1  tint write can be accepted.
REQ-010 tint_pending  output  1  an accepted tint is waiting for the next frame boundary.
REQ-011 r_out, g_out, b_out  output  DW each  tinted colour.
REQ-012 hs_out, vs_out, hb_out, vb_out, de_out  output  1 each  delayed timing; de_out is display enable.

Function
REQ-013 Pipeline SHALL be exactly 2 cycles from y_in and timing inputs to all outputs, for every value of enable.
REQ-014 de_out SHALL equal ~(hb_in | vb_in), delayed 2 cycles.
REQ-015 Stage 1 SHALL register P_c = y_in * (T_c + 1) for c in {R,G,B}, where T_c is the 8-bit active tint, each product DW+9 bits wide.
REQ-016 Stage 2 SHALL register c_out = P_c[DW+7:8]; T_c=255 gives c_out = y_in exactly, and no overflow or saturation case exists.
REQ-017 With enable low, r_out = g_out = b_out = y_in, delayed 2 cycles; the active tint is ignored but keeps its value.
REQ-018 enable SHALL be sampled in stage 1 and carried with the data, so a toggle never mixes modes within one sample.
REQ-019 Config FSM states: IDLE and PENDING.
- IDLE: cfg_ready=1, tint_pending=0.
- PENDING: cfg_ready=0, tint_pending=1.
REQ-020 IDLE to PENDING: when cfg_valid and cfg_ready are both high, cfg_data SHALL be captured into the shadow tint register.
REQ-021 PENDING to IDLE: on a vs_in rising edge (vs_in=1 and previous vs_in=0), the shadow SHALL be copied to the active tint; the new tint applies from the sample entering stage 1 in the following cycle.
REQ-022 The active tint SHALL change only at a vs_in rising edge, never mid-frame.
REQ-023 cfg_valid while in PENDING SHALL be ignored (no capture); the requester holds cfg_valid until cfg_ready.
REQ-024 If a write is accepted in the same cycle as a vs_in rising edge, that edge SHALL NOT commit it; the write commits at the next rising edge.
REQ-025 A vs_in rising edge in IDLE SHALL have no effect.

Reset
REQ-026 During reset:
- active and shadow tint SHALL be 0xFFFFFF (identity grey);
- state SHALL be IDLE;
- the previous-vs register SHALL be 1, so no spurious edge follows reset;
- all pipeline registers and outputs SHALL be 0, including de_out.
REQ-027 Reset asserted in PENDING SHALL discard the shadow tint; no commit occurs.
REQ-028 cfg_ready SHALL be 0 while reset is high, and 1 in the first cycle after reset deasserts.

Configuration
REQ-029 Macro GRAY2TINT_ROUND_EN.
- Defined: stage 2 SHALL output (P_c + 128)[DW+7:8], i.e. round to nearest.
- Undefined: stage 2 SHALL truncate as in REQ-016.
- Latency and the identity result for T_c=255 SHALL be the same in both builds.

Verification
REQ-030 Reset, enable=1, y_in=0x80 -> r/g/b_out=0x80 exactly 2 cycles later; de_out follows ~(hb|vb) with 2-cycle delay.
REQ-031 Write 0x7F3F00, then pulse vs_in high, then y_in=0xC8:
- truncating build -> r=0x64, g=0x32, b=0x00;
- GRAY2TINT_ROUND_EN build -> r=0x64, g=0x32, b=0x01.
REQ-032 Write a tint mid-frame, no vs edge, y_in=0xC8 -> output remains 0xC8 grey, tint_pending=1, cfg_ready=0; after the vs_in rise, tint_pending=0.
REQ-033 cfg_valid accepted in the same cycle as a vs_in rise -> no commit at that edge; commit at the next rise.
REQ-034 Reset asserted while PENDING -> tint_pending=0 and output is identity grey after the next vs edge.
REQ-035 enable toggled low with active tint 0x7F3F00, y_in=0xC8 -> r/g/b_out=0xC8 with the same 2-cycle latency; re-enabling restores the tint without a new write.

Source files
------------

// File: rtl/gray2tint.sv
// gray2tint: colourises a luma stream with a programmable 8-bit-per-channel tint.
//
// Each channel computes y * (T + 1) >> 8 over a fixed two-stage pipeline.
// The tint is written through a one-deep shadow register and reaches the
// datapath only at a rising edge of vs_in, so a frame never changes colour
// part way through.
//
// Build option: define GRAY2TINT_ROUND_EN to round the channel result to
// nearest instead of truncating. Latency and the identity result (T = 0xFF)
// are the same in both builds.

// One colour channel: stage 1 multiplies, stage 2 drops the fraction.
module gray2tint_lane #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic [DW-1:0] y_in,
  input  logic [7:0]    tint,
  output logic [DW-1:0] c_out
);
  localparam int PW = DW + 9;

`ifdef GRAY2TINT_ROUND_EN
  localparam logic [PW-1:0] RND = PW'(128);
`else
  localparam logic [PW-1:0] RND = PW'(0);
`endif

  // Passthrough reuses the multiplier with a gain of 256. Because y * 256 >> 8
  // is exactly y, and the rounding constant never carries into bit 8, enable
  // rides along as the gain. That way a sample can never mix modes.
  logic [8:0]    gain;
  logic [PW-1:0] prod_q;
  logic [PW-1:0] prod_adj;
  logic          unused_bits;

  assign gain = enable ? ({1'b0, tint} + 9'd1) : 9'd256;

  // Stage 1: register the full-width product.
  always_ff @(posedge clk) begin
    if (reset) prod_q <= '0;
    else       prod_q <= PW'(y_in) * PW'(gain);
  end

  assign prod_adj = prod_q + RND;

  // Stage 2: keep the integer part. It cannot exceed y_in, so no saturation is needed.
  always_ff @(posedge clk) begin
    if (reset) c_out <= '0;
    else       c_out <= prod_adj[DW+7:8];
  end

  // The MSB and the fraction bits are zero or discarded by construction.
  assign unused_bits = ^{prod_adj[PW-1], prod_adj[7:0]};
endmodule

module gray2tint #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic [DW-1:0] y_in,
  input  logic          hs_in,
  input  logic          vs_in,
  input  logic          hb_in,
  input  logic          vb_in,
  input  logic          cfg_valid,
  input  logic [23:0]   cfg_data,
  output logic          cfg_ready,
  output logic          tint_pending,
  output logic [DW-1:0] r_out,
  output logic [DW-1:0] g_out,
  output logic [DW-1:0] b_out,
  output logic          hs_out,
  output logic          vs_out,
  output logic          hb_out,
  output logic          vb_out,
  output logic          de_out
);
  localparam int NUM_CH = 3;
  localparam int TW     = 8;
  localparam int STAGES = 2;

  typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} cfg_state_t;

  typedef struct packed {
    logic hs;
    logic vs;
    logic hb;
    logic vb;
    logic de;
  } timing_t;

  // Channel index 2 = R, 1 = G, 0 = B, which matches the cfg_data packing.
  logic [NUM_CH-1:0][TW-1:0] tint_act;
  logic [NUM_CH-1:0][TW-1:0] tint_shd;
  logic [NUM_CH-1:0][DW-1:0] lane_out;
  timing_t [STAGES:1]        tim_pipe;
  cfg_state_t                state;
  logic                      vs_prev;
  logic                      vs_rise;

  assign vs_rise = vs_in & ~vs_prev;

  // Tint config FSM. Acceptance only happens in IDLE and commit only in PENDING,
  // so a write accepted on a vs edge waits for the next edge. vs_prev resets
  // high so that vs already being high after reset is not seen as an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      tint_act <= '1;
      tint_shd <= '1;
      vs_prev  <= 1'b1;
    end else begin
      vs_prev <= vs_in;
      case (state)
        IDLE: begin
          if (cfg_valid) begin
            tint_shd <= cfg_data;
            state    <= PENDING;
          end
        end
        PENDING: begin
          if (vs_rise) begin
            tint_act <= tint_shd;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // cfg_ready is gated by reset so that it reads low for the whole time reset is held.
  assign cfg_ready    = (state == IDLE) & ~reset;
  assign tint_pending = (state == PENDING);

  // Timing side-band delay line. Its length matches the lanes' two register stages.
  always_ff @(posedge clk) begin
    if (reset) begin
      tim_pipe <= '0;
    end else begin
      tim_pipe[1] <= '{hs: hs_in, vs: vs_in, hb: hb_in, vb: vb_in, de: ~(hb_in | vb_in)};
      for (int s = 2; s <= STAGES; s++) tim_pipe[s] <= tim_pipe[s-1];
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    gray2tint_lane #(.DW(DW)) u_lane (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .y_in   (y_in),
      .tint   (tint_act[c]),
      .c_out  (lane_out[c])
    );
  end

  assign r_out  = lane_out[2];
  assign g_out  = lane_out[1];
  assign b_out  = lane_out[0];
  assign hs_out = tim_pipe[STAGES].hs;
  assign vs_out = tim_pipe[STAGES].vs;
  assign hb_out = tim_pipe[STAGES].hb;
  assign vb_out = tim_pipe[STAGES].vb;
  assign de_out = tim_pipe[STAGES].de;
endmodule
